// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with scoreboard busy bits.
//   Two combinational read ports, one write port and one reservation port.
//   Register 0 is hardwired to zero.
//   A reservation marks a register as waiting for a result. A later write to
//   that register clears the mark.
//   Ports:
//     clk, rst            rising-edge clock, async active-high reset
//     ra1/ra2 -> rd1/rd2  read addresses and read data (0-cycle latency)
//     busy1/busy2         pending-result flag for the register at ra1/ra2
//     wa/wd/we            write address, write data, write enable (1-cycle latency)
//     rsv_en/rsv_addr     reserve request and the register it reserves
//     cpu_out             registered contents of the top register (DEPTH-1)
//     out_valid           one-cycle pulse after each write to DEPTH-1
//   Parameters:
//     DATA_W              register width
//     ADDR_W              address width (DEPTH = 2**ADDR_W)
//     BYPASS              nonzero enables write-to-read forwarding
module reg_file_sb #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              we,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  output logic [DATA_W-1:0] cpu_out,
  output logic              out_valid
);

  localparam int unsigned     DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam bit              BYP   = (BYPASS != 0);

  logic [DATA_W-1:0] r_rf [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic              r_out_valid;

  logic w_wr;
  logic w_rsv;
  logic w_byp1;
  logic w_byp2;
  logic w_rsv1;
  logic w_rsv2;

  // Writes and reservations to address 0 are dropped here.
  assign w_wr  = we && (wa != '0);
  assign w_rsv = rsv_en && (rsv_addr != '0);

  // Next busy vector. The reservation is applied last so that it wins over a
  // same-address write.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr) begin
      w_busy_nxt[wa] = 1'b0;
    end
    if (w_rsv) begin
      w_busy_nxt[rsv_addr] = 1'b1;
    end
  end

  // Storage, busy bits and the write-to-top pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_rf[i] <= '0;
      end
      r_busy      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_wr) begin
        r_rf[wa] <= wd;
      end
      r_busy      <= w_busy_nxt;
      r_out_valid <= we && (wa == LAST);
    end
  end

  // Forwarding of an in-flight write to each read port.
  assign w_byp1 = BYP && w_wr && (ra1 == wa);
  assign w_byp2 = BYP && w_wr && (ra2 == wa);
  assign w_rsv1 = w_rsv && (rsv_addr == ra1);
  assign w_rsv2 = w_rsv && (rsv_addr == ra2);

  assign rd1 = w_byp1 ? wd : ((ra1 == '0) ? '0 : r_rf[ra1]);
  assign rd2 = w_byp2 ? wd : ((ra2 == '0) ? '0 : r_rf[ra2]);

  // A forwarded write hides the pending flag unless the register is being
  // reserved again in the same cycle.
  assign busy1 = r_busy[ra1] && !(w_byp1 && !w_rsv1);
  assign busy2 = r_busy[ra2] && !(w_byp2 && !w_rsv2);

  // The top register is exposed directly and is never forwarded.
  assign cpu_out   = r_rf[LAST];
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: randomized and directed checks of reg_file_sb against a
// behavioural model. There are two instances:
//   - A: default parameters.
//   - B: DATA_W=16, ADDR_W=5, BYPASS=0.
module tb_reg_file_sb;

  logic clk;
  logic rst;

  // Instance A (defaults)
  logic [3:0] a_ra1, a_ra2, a_wa, a_rsv_addr;
  logic [7:0] a_wd;
  logic       a_we, a_rsv_en;
  logic [7:0] a_rd1, a_rd2, a_cpu_out;
  logic       a_busy1, a_busy2, a_out_valid;

  // Instance B (wide, no bypass)
  logic [4:0]  b_ra1, b_ra2, b_wa, b_rsv_addr;
  logic [15:0] b_wd;
  logic        b_we, b_rsv_en;
  logic [15:0] b_rd1, b_rd2, b_cpu_out;
  logic        b_busy1, b_busy2, b_out_valid;

  int unsigned n_vec;
  int unsigned n_err;

  // Reference model state
  logic [7:0]  ma_rf [16];
  bit          ma_busy [16];
  bit          ma_ov;
  logic [15:0] mb_rf [32];
  bit          mb_busy [32];
  bit          mb_ov;

  reg_file_sb u_dut_a (
    .clk(clk), .rst(rst), .ra1(a_ra1), .ra2(a_ra2), .wa(a_wa), .wd(a_wd),
    .we(a_we), .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr), .rd1(a_rd1),
    .rd2(a_rd2), .busy1(a_busy1), .busy2(a_busy2), .cpu_out(a_cpu_out),
    .out_valid(a_out_valid)
  );

  reg_file_sb #(.DATA_W(16), .ADDR_W(5), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst(rst), .ra1(b_ra1), .ra2(b_ra2), .wa(b_wa), .wd(b_wd),
    .we(b_we), .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr), .rd1(b_rd1),
    .rd2(b_rd2), .busy1(b_busy1), .busy2(b_busy2), .cpu_out(b_cpu_out),
    .out_valid(b_out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [7:0] exp_a_rd(input logic [3:0] ra);
    if (a_we && a_wa != 4'd0 && ra == a_wa) return a_wd;
    if (ra == 4'd0) return 8'h00;
    return ma_rf[ra];
  endfunction

  function automatic bit exp_a_busy(input logic [3:0] ra);
    if (ra == 4'd0) return 1'b0;
    if (a_we && a_wa == ra && !(a_rsv_en && a_rsv_addr == ra)) return 1'b0;
    return ma_busy[ra];
  endfunction

  function automatic logic [15:0] exp_b_rd(input logic [4:0] ra);
    if (ra == 5'd0) return 16'h0000;
    return mb_rf[ra];
  endfunction

  task automatic clear_models();
    for (int i = 0; i < 16; i++) begin
      ma_rf[i] = 8'h00;
      ma_busy[i] = 1'b0;
    end
    for (int i = 0; i < 32; i++) begin
      mb_rf[i] = 16'h0000;
      mb_busy[i] = 1'b0;
    end
    ma_ov = 1'b0;
    mb_ov = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check_val($sformatf("%s_a_rd1", tag), 32'(a_rd1), 32'(exp_a_rd(a_ra1)));
    check_val($sformatf("%s_a_rd2", tag), 32'(a_rd2), 32'(exp_a_rd(a_ra2)));
    check_val($sformatf("%s_a_busy1", tag), 32'(a_busy1), 32'(exp_a_busy(a_ra1)));
    check_val($sformatf("%s_a_busy2", tag), 32'(a_busy2), 32'(exp_a_busy(a_ra2)));
    check_val($sformatf("%s_a_cpu_out", tag), 32'(a_cpu_out), 32'(ma_rf[15]));
    check_val($sformatf("%s_a_out_valid", tag), 32'(a_out_valid), 32'(ma_ov));
    check_val($sformatf("%s_b_rd1", tag), 32'(b_rd1), 32'(exp_b_rd(b_ra1)));
    check_val($sformatf("%s_b_rd2", tag), 32'(b_rd2), 32'(exp_b_rd(b_ra2)));
    check_val($sformatf("%s_b_busy1", tag), 32'(b_busy1), 32'(mb_busy[b_ra1]));
    check_val($sformatf("%s_b_busy2", tag), 32'(b_busy2), 32'(mb_busy[b_ra2]));
    check_val($sformatf("%s_b_cpu_out", tag), 32'(b_cpu_out), 32'(mb_rf[31]));
    check_val($sformatf("%s_b_out_valid", tag), 32'(b_out_valid), 32'(mb_ov));
  endtask

  // Model of one rising edge: write, then reservation (the reservation wins).
  task automatic model_edge();
    if (!rst) begin
      ma_ov = a_we && (a_wa == 4'd15);
      if (a_we && a_wa != 4'd0) begin
        ma_rf[a_wa] = a_wd;
        ma_busy[a_wa] = 1'b0;
      end
      if (a_rsv_en && a_rsv_addr != 4'd0) ma_busy[a_rsv_addr] = 1'b1;
      mb_ov = b_we && (b_wa == 5'd31);
      if (b_we && b_wa != 5'd0) begin
        mb_rf[b_wa] = b_wd;
        mb_busy[b_wa] = 1'b0;
      end
      if (b_rsv_en && b_rsv_addr != 5'd0) mb_busy[b_rsv_addr] = 1'b1;
    end
  endtask

  // Called at posedge+1 after the inputs are driven. Checks at the falling
  // edge, then advances one clock.
  task automatic tick(input string tag);
    #4;
    check_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drv_a(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa,
                       input logic [7:0] wd, input logic we, input logic rsv_en,
                       input logic [3:0] rsv_addr);
    a_ra1 = ra1; a_ra2 = ra2; a_wa = wa; a_wd = wd; a_we = we;
    a_rsv_en = rsv_en; a_rsv_addr = rsv_addr;
  endtask

  task automatic drv_b(input logic [4:0] ra1, input logic [4:0] ra2, input logic [4:0] wa,
                       input logic [15:0] wd, input logic we, input logic rsv_en,
                       input logic [4:0] rsv_addr);
    b_ra1 = ra1; b_ra2 = ra2; b_wa = wa; b_wd = wd; b_we = we;
    b_rsv_en = rsv_en; b_rsv_addr = rsv_addr;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    clear_models();
    drv_a(4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0);
    drv_b(5'd0, 5'd0, 5'd0, 16'h0000, 1'b0, 1'b0, 5'd0);
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Write A5 to register 3, forwarded during the write, visible afterwards
    drv_a(4'd3, 4'd3, 4'd3, 8'hA5, 1'b1, 1'b0, 4'd0);
    tick("wr3");
    drv_a(4'd3, 4'd3, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0);
    tick("rd3");

    // Register 0 ignores writes and reservations
    drv_a(4'd0, 4'd3, 4'd0, 8'hFF, 1'b1, 1'b1, 4'd0);
    tick("wr0");
    drv_a(4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0);
    tick("rd0");

    // Reserve 5, write 5 clears busy, then reserve and write 5 together
    drv_a(4'd5, 4'd3, 4'd0, 8'h00, 1'b0, 1'b1, 4'd5);
    tick("rsv5");
    check_val("rsv5_busy1_after", 32'(a_busy1), 32'd1);
    drv_a(4'd5, 4'd5, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0);
    tick("rsv5_hold");
    drv_a(4'd5, 4'd6, 4'd5, 8'h3C, 1'b1, 1'b0, 4'd0);
    tick("wr5");
    drv_a(4'd5, 4'd6, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0);
    tick("rd5");
    drv_a(4'd5, 4'd5, 4'd5, 8'h3C, 1'b1, 1'b1, 4'd5);
    tick("rsv_wr5");
    drv_a(4'd5, 4'd5, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0);
    tick("rsv_wr5_after");
    // Reservation and write to different registers in the same cycle
    drv_a(4'd7, 4'd5, 4'd5, 8'h11, 1'b1, 1'b1, 4'd7);
    tick("split");
    drv_a(4'd7, 4'd5, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0);
    tick("split_after");

    // Write 7E to the top register: single-cycle pulse, then back-to-back
    drv_a(4'd15, 4'd1, 4'd15, 8'h7E, 1'b1, 1'b0, 4'd0);
    tick("wr15");
    check_val("wr15_cpu_out", 32'(a_cpu_out), 32'h7E);
    check_val("wr15_out_valid", 32'(a_out_valid), 32'd1);
    drv_a(4'd15, 4'd1, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0);
    tick("wr15_idle");
    check_val("wr15_pulse_end", 32'(a_out_valid), 32'd0);
    drv_a(4'd15, 4'd15, 4'd15, 8'h81, 1'b1, 1'b0, 4'd0);
    tick("b2b_1");
    drv_a(4'd15, 4'd15, 4'd15, 8'h82, 1'b1, 1'b0, 4'd0);
    tick("b2b_2");
    drv_a(4'd15, 4'd15, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0);
    tick("b2b_3");
    tick("b2b_4");

    // Wide instance: write to top, no forwarding of same-cycle reads
    drv_b(5'd31, 5'd31, 5'd31, 16'hBEEF, 1'b1, 1'b0, 5'd0);
    tick("b_wr31");
    check_val("b_wr31_cpu_out", 32'(b_cpu_out), 32'hBEEF);
    drv_b(5'd31, 5'd31, 5'd31, 16'h1234, 1'b1, 1'b1, 5'd9);
    tick("b_wr31_old");
    drv_b(5'd9, 5'd31, 5'd9, 16'h0F0F, 1'b1, 1'b0, 5'd0);
    tick("b_wr9_busy_held");
    drv_b(5'd9, 5'd31, 5'd0, 16'h0000, 1'b0, 1'b0, 5'd0);
    tick("b_rd9");

    // Randomized traffic on both instances
    for (int n = 0; n < 400; n++) begin
      logic [3:0] wa4, r14, r24, rs4;
      logic [4:0] wa5, r15, r25, rs5;
      wa4 = 4'($urandom_range(0, 15));
      r14 = ($urandom_range(0, 2) == 0) ? wa4 : 4'($urandom_range(0, 15));
      r24 = ($urandom_range(0, 3) == 0) ? r14 : 4'($urandom_range(0, 15));
      rs4 = ($urandom_range(0, 3) == 0) ? wa4 : 4'($urandom_range(0, 15));
      drv_a(r14, r24, wa4, 8'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0), rs4);
      wa5 = 5'($urandom_range(0, 31));
      r15 = ($urandom_range(0, 2) == 0) ? wa5 : 5'($urandom_range(0, 31));
      r25 = 5'($urandom_range(0, 31));
      rs5 = ($urandom_range(0, 3) == 0) ? wa5 : 5'($urandom_range(0, 31));
      drv_b(r15, r25, wa5, 16'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0), rs5);
      tick("rand");
    end

    // Load and reserve, then assert reset between edges
    drv_a(4'd4, 4'd6, 4'd4, 8'h44, 1'b1, 1'b1, 4'd6);
    drv_b(5'd4, 5'd6, 5'd4, 16'h4444, 1'b1, 1'b1, 5'd6);
    tick("pre_rst");
    drv_a(4'd4, 4'd6, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0);
    drv_b(5'd4, 5'd6, 5'd0, 16'h0000, 1'b0, 1'b0, 5'd0);
    #2;
    rst = 1'b1;
    clear_models();
    #1;
    check_all("async_rst");
    check_val("async_rst_busy2", 32'(a_busy2), 32'd0);
    @(posedge clk);
    #1;
    // Writes and reservations are ignored while reset is held. Forwarding
    // still shows the write data on the read port.
    drv_a(4'd7, 4'd6, 4'd7, 8'h55, 1'b1, 1'b1, 4'd6);
    drv_b(5'd7, 5'd6, 5'd7, 16'h5555, 1'b1, 1'b1, 5'd6);
    tick("rst_hold");
    drv_a(4'd7, 4'd6, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0);
    drv_b(5'd7, 5'd6, 5'd0, 16'h0000, 1'b0, 1'b0, 5'd0);
    #1;
    check_all("rst_hold_after");
    rst = 1'b0;
    @(posedge clk);
    #1;
    // The first edge after reset release behaves normally
    drv_a(4'd7, 4'd15, 4'd15, 8'h99, 1'b1, 1'b1, 4'd7);
    tick("post_rst");
    drv_a(4'd7, 4'd15, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0);
    tick("post_rst_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
